// File: rtl/seg_pkg.sv
// Shared constants for the scanned seven-segment display controller.
// Register offsets, control bit indices and blank patterns.
package seg_pkg;

    localparam logic [31:0] DISP_VALUE_OFS = 32'd0;
    localparam logic [31:0] DISP_CTRL_OFS  = 32'd4;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_LZB = 1;

    localparam logic [1:0] CTRL_RST = 2'b01;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low one-hot anode select for digit index d.
    function automatic logic [7:0] an_sel(input logic [2:0] d);
        return ~(8'b1 << d);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Ports: nib[3:0] in; seg[6:0] out (seg[0]=a .. seg[6]=g).
module seg_hex_decode (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        unique case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Memory-mapped 8-digit scanned hex display with frame-synced shadow.
// Ports: clk, rst (sync, active-high); wr_en/wr_addr/wr_data store
// port; rd_addr/rd_data combinational readback; seg[6:0], an[7:0]
// active-low registered display outputs.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter logic [31:0] IO_BASE     = 32'hFFFF_0000,
    parameter int          REFRESH_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic [6:0]  seg,
    output logic [7:0]  an
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    localparam logic [31:0] VALUE_ADDR = IO_BASE + DISP_VALUE_OFS;
    localparam logic [31:0] CTRL_ADDR  = IO_BASE + DISP_CTRL_OFS;

    logic [31:0]   disp_value;
    logic [1:0]    disp_ctrl;
    logic [31:0]   shadow;
    logic [CW-1:0] cnt;
    logic [2:0]    d;

    logic          wr_value;
    logic          wr_ctrl;
    logic          cnt_wrap;
    logic          frame_wrap;
    logic [4:0]    bit_ofs;
    logic [3:0]    nib;
    logic [31:0]   upper;
    logic          lz_blank;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_nxt;
    logic [7:0]    an_nxt;

    assign wr_value   = wr_en && (wr_addr == VALUE_ADDR);
    assign wr_ctrl    = wr_en && (wr_addr == CTRL_ADDR);
    assign cnt_wrap   = (cnt == CNT_MAX);
    assign frame_wrap = cnt_wrap && (d == 3'd7);

    assign bit_ofs = {d, 2'b00};
    assign nib     = shadow[bit_ofs +: 4];

    // Digit is a leading zero when it and everything above it is zero;
    // digit 0 is never blanked so a zero value still shows "0".
    assign upper    = shadow >> bit_ofs;
    assign lz_blank = disp_ctrl[CTRL_LZB] && (d != 3'd0)
                      && (upper == 32'd0);

    seg_hex_decode u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    always_comb begin
        an_nxt  = an_sel(d);
        seg_nxt = dec_seg;
        if (!disp_ctrl[CTRL_EN]) begin
            an_nxt  = AN_OFF;
            seg_nxt = SEG_OFF;
        end else if (lz_blank) begin
            an_nxt = AN_OFF;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        if (rd_addr == VALUE_ADDR) begin
            rd_data = disp_value;
        end else if (rd_addr == CTRL_ADDR) begin
            rd_data = {30'd0, disp_ctrl};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_value <= 32'd0;
            disp_ctrl  <= CTRL_RST;
            shadow     <= 32'd0;
            cnt        <= '0;
            d          <= 3'd0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
        end else begin
            if (wr_value) begin
                disp_value <= wr_data;
            end
            if (wr_ctrl) begin
                disp_ctrl <= wr_data[1:0];
            end
            // Old value is captured when a store lands on the wrap edge.
            if (frame_wrap) begin
                shadow <= disp_value;
            end
            if (cnt_wrap) begin
                cnt <= '0;
                d   <= d + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule
